// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity codes and baud divider helper
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous byte FIFO with registered head output
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok, push_ok;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CNT_FULL) || pop_ok);

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
  end

  // Storage and pointers; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with output FIFO and error pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_rxd,
  output logic [7:0] O_data,
  output logic       O_valid,
  input  logic       I_ready,
  output logic       O_busy,
  output logic       O_frame_err,
  output logic       O_parity_err,
  output logic       O_overrun
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] T_S0     = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] T_S1     = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] T_DEC    = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] T_LAST   = TICK_W'(OVERSAMPLE - 1);

  rx_state_t         state_q;
  logic              rxd_meta_q, rxd_sync_q;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              s0_q, s1_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic              par_err_q;
  logic              frame_err_q, parity_err_q, overrun_q;

  logic tick, at_s0, at_s1, decide, bit_end, maj, par_exp;
  logic fifo_full, fifo_empty, fifo_push, pop_eff;

  // Two-flop synchroniser; reset high so an idle line never looks like a start bit
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= I_rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Baud/oversample counter next-state; held at zero in IDLE so each frame aligns to its falling edge
  always_comb begin
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    tick_cnt_d = tick_cnt_q;
    if (state_q == RX_IDLE) begin
      div_cnt_d  = '0;
      tick_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d  = '0;
      tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
    end
  end

  // Baud/oversample counter registers
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick    = (state_q != RX_IDLE) && (div_cnt_q == DIV_LAST);
  assign at_s0   = tick && (tick_cnt_q == T_S0);
  assign at_s1   = tick && (tick_cnt_q == T_S1);
  assign decide  = tick && (tick_cnt_q == T_DEC);
  assign bit_end = tick && (tick_cnt_q == T_LAST);

  // Third sample is the live synchronised value at the decision tick
  assign maj = (s0_q & s1_q) | (s0_q & rxd_sync_q) | (s1_q & rxd_sync_q);

  assign par_exp = (PARITY == PAR_EVEN) ? ^shift_q :
                   (PARITY == PAR_ODD)  ? ~^shift_q : 1'b0;

  assign pop_eff   = I_ready && !fifo_empty;
  assign fifo_push = (state_q == RX_STOP) && decide && maj && !par_err_q &&
                     (!fifo_full || pop_eff);

  // Receive FSM: framing, bit assembly and registered error pulses
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= RX_IDLE;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      if (at_s0) s0_q <= rxd_sync_q;
      if (at_s1) s1_q <= rxd_sync_q;
      case (state_q)
        RX_IDLE: begin
          if (!rxd_sync_q) begin
            state_q   <= RX_START;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
          end
        end
        RX_START: begin
          if (decide && maj) state_q <= RX_IDLE;
          else if (bit_end)  state_q <= RX_DATA;
        end
        RX_DATA: begin
          if (decide) shift_q <= {maj, shift_q[7:1]};
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) state_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            else bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        RX_PARITY: begin
          if (decide)  par_err_q <= (maj != par_exp);
          if (bit_end) state_q <= RX_STOP;
        end
        RX_STOP: begin
          // Return to IDLE at mid-stop so the next start edge is caught promptly
          if (decide) begin
            state_q <= RX_IDLE;
            if (!maj)                         frame_err_q  <= 1'b1;
            else if (par_err_q)               parity_err_q <= 1'b1;
            else if (fifo_full && !pop_eff)   overrun_q    <= 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (I_clk),
    .rst_i   (I_rst),
    .push_i  (fifo_push),
    .data_i  (shift_q),
    .pop_i   (I_ready),
    .data_o  (O_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign O_valid      = !fifo_empty;
  assign O_busy       = (state_q != RX_IDLE);
  assign O_frame_err  = frame_err_q;
  assign O_parity_err = parity_err_q;
  assign O_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (8N1 and even-parity instances)
module tb_uart_rx;

  localparam int BIT_CLKS = 240;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd_a, rxd_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b;
  logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int valid_cyc_a = 0, pops_a = 0, fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0;
  int pops_b = 0, pe_cnt_b = 0, fe_cnt_b = 0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00;

  int snap_pops, snap_fe, snap_pe, snap_ov, snap_vc;
  logic [7:0] expv;

  always #5 clk = ~clk;

  uart_rx u_dut_a (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_rxd        (rxd_a),
    .O_data       (data_a),
    .O_valid      (valid_a),
    .I_ready      (ready_a),
    .O_busy       (busy_a),
    .O_frame_err  (fe_a),
    .O_parity_err (pe_a),
    .O_overrun    (ov_a)
  );

  uart_rx #(.PARITY(2)) u_dut_b (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_rxd        (rxd_b),
    .O_data       (data_b),
    .O_valid      (valid_b),
    .I_ready      (ready_b),
    .O_busy       (busy_b),
    .O_frame_err  (fe_b),
    .O_parity_err (pe_b),
    .O_overrun    (ov_b)
  );

  // Event monitor on the falling edge; inputs change only at posedge+2
  always @(negedge clk) begin
    if (valid_a) valid_cyc_a++;
    if (valid_a && ready_a) begin pops_a++; last_a = data_a; end
    if (fe_a) fe_cnt_a++;
    if (pe_a) pe_cnt_a++;
    if (ov_a) ov_cnt_a++;
    if (valid_b && ready_b) begin pops_b++; last_b = data_b; end
    if (pe_b) pe_cnt_b++;
    if (fe_b) fe_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic line(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v);
    line(sel, v);
    cyc(BIT_CLKS);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    hold_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
    if (has_par) hold_bit(sel, par);
    hold_bit(sel, stop);
    line(sel, 1'b1);
  endtask

  task automatic snap;
    snap_pops = pops_a;
    snap_fe   = fe_cnt_a;
    snap_pe   = pe_cnt_a;
    snap_ov   = ov_cnt_a;
    snap_vc   = valid_cyc_a;
  endtask

  initial begin
    rst     = 1'b1;
    rxd_a   = 1'b1;
    rxd_b   = 1'b1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    cyc(3);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_data",  32'(data_a),  32'h00);
    check("rst_flags", 32'({fe_a, pe_a, ov_a}), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    rst = 1'b0;
    cyc(20);

    // 0xA5 8N1, consumer always ready
    ready_a = 1'b1;
    snap();
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    cyc(300);
    check("a5_pops",  32'(pops_a - snap_pops), 32'd1);
    check("a5_data",  32'(last_a), 32'hA5);
    check("a5_vcyc",  32'(valid_cyc_a - snap_vc), 32'd1);
    check("a5_flags", 32'((fe_cnt_a - snap_fe) + (pe_cnt_a - snap_pe) + (ov_cnt_a - snap_ov)), 32'd0);

    // False start: 60 clocks low
    snap();
    line(1'b0, 1'b0);
    cyc(30);
    check("glitch_busy_mid", 32'(busy_a), 32'd1);
    cyc(30);
    line(1'b0, 1'b1);
    cyc(400);
    check("glitch_busy", 32'(busy_a), 32'd0);
    check("glitch_valid", 32'(valid_a), 32'd0);
    check("glitch_fe", 32'(fe_cnt_a - snap_fe), 32'd0);
    check("glitch_pops", 32'(pops_a - snap_pops), 32'd0);

    // 0x3C with stop bit low
    snap();
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(600);
    check("frm_fe_pulse", 32'(fe_cnt_a - snap_fe), 32'd1);
    check("frm_pops", 32'(pops_a - snap_pops), 32'd0);
    check("frm_vcyc", 32'(valid_cyc_a - snap_vc), 32'd0);
    check("frm_busy", 32'(busy_a), 32'd0);

    // Overrun: consumer stalled, five bytes into a four-entry FIFO
    ready_a = 1'b0;
    snap();
    for (int i = 0; i < 5; i++) send_frame(1'b0, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1);
    cyc(300);
    check("ovr_pulse", 32'(ov_cnt_a - snap_ov), 32'd1);
    check("ovr_fe", 32'(fe_cnt_a - snap_fe), 32'd0);
    for (int i = 0; i < 4; i++) begin
      expv = 8'h11 + 8'(i);
      check("drain_valid", 32'(valid_a), 32'd1);
      check("drain_data", 32'(data_a), 32'(expv));
      ready_a = 1'b1;
      cyc(1);
      ready_a = 1'b0;
    end
    check("drain_empty", 32'(valid_a), 32'd0);

    // Even parity on instance B: 0x01 needs parity bit 1
    ready_b = 1'b1;
    send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    cyc(300);
    check("par_bad_pulse", 32'(pe_cnt_b), 32'd1);
    check("par_bad_pops", 32'(pops_b), 32'd0);
    send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
    cyc(300);
    check("par_ok_pops", 32'(pops_b), 32'd1);
    check("par_ok_data", 32'(last_b), 32'h01);
    check("par_ok_pe", 32'(pe_cnt_b), 32'd1);
    check("par_ok_fe", 32'(fe_cnt_b), 32'd0);

    // Reset during data bit 3 with a byte already queued
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    cyc(300);
    check("pre_rst_valid", 32'(valid_a), 32'd1);
    snap();
    hold_bit(1'b0, 1'b0);
    hold_bit(1'b0, 1'b0);
    hold_bit(1'b0, 1'b1);
    hold_bit(1'b0, 1'b0);
    line(1'b0, 1'b1);
    cyc(120);
    check("mid_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    cyc(2);
    check("mrst_valid", 32'(valid_a), 32'd0);
    check("mrst_busy", 32'(busy_a), 32'd0);
    check("mrst_data", 32'(data_a), 32'h00);
    rst = 1'b0;
    cyc(300);
    check("mrst_flags", 32'((fe_cnt_a - snap_fe) + (pe_cnt_a - snap_pe) + (ov_cnt_a - snap_ov)), 32'd0);
    ready_a = 1'b1;
    snap();
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    cyc(300);
    check("post_rst_pops", 32'(pops_a - snap_pops), 32'd1);
    check("post_rst_data", 32'(last_a), 32'h5A);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
